// File: rtl/VX_tcu_pkg.sv
// Shared TCU types: step width, micro-op descriptor, sequencer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package VX_tcu_pkg;

    localparam int TCU_STEP_W = 4;
    localparam int TCU_HDR_W  = 64;
    localparam int TCU_IDX_W  = 12;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_e;

    // One micro-op as seen by the core: which A/B sub-block plus chain markers.
    typedef struct packed {
        logic [TCU_STEP_W-1:0] step_m;
        logic [TCU_STEP_W-1:0] step_n;
        logic [TCU_STEP_W-1:0] step_k;
        logic                  first;
        logic                  last;
    } tcu_uop_t;

endpackage

// File: rtl/vx_tcu_step_ctr.sv
// Three-level nested step counter, n innermost, then m, k outermost.
// Latency: counters update on the edge after i_inc/i_clear; o_wrap is combinational from state.
// Backpressure: none; advances only when i_inc is asserted by the owner.
module vx_tcu_step_ctr
    import VX_tcu_pkg::*;
#(
    parameter int STEP_W = TCU_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_inc,
    input  logic [STEP_W-1:0] i_m_last,
    input  logic [STEP_W-1:0] i_n_last,
    input  logic [STEP_W-1:0] i_k_last,
    output logic [STEP_W-1:0] o_step_m,
    output logic [STEP_W-1:0] o_step_n,
    output logic [STEP_W-1:0] o_step_k,
    output logic              o_wrap
);

    logic [STEP_W-1:0] r_m;
    logic [STEP_W-1:0] r_n;
    logic [STEP_W-1:0] r_k;

    logic w_m_end;
    logic w_n_end;
    logic w_k_end;

    // Compare against the inclusive bounds so a bound of all-ones never overflows early.
    always_comb begin
        w_m_end = (r_m == i_m_last);
        w_n_end = (r_n == i_n_last);
        w_k_end = (r_k == i_k_last);
    end

    // Nested increment; on the final step everything returns to zero.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (i_inc) begin
            if (!w_n_end) begin
                r_n <= r_n + 1'b1;
            end else begin
                r_n <= '0;
                if (!w_m_end) begin
                    r_m <= r_m + 1'b1;
                end else begin
                    r_m <= '0;
                    if (!w_k_end) begin
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_k <= '0;
                    end
                end
            end
        end
    end

    assign o_step_m = r_m;
    assign o_step_n = r_n;
    assign o_step_k = r_k;
    assign o_wrap   = w_m_end && w_n_end && w_k_end;

endmodule

// File: rtl/vx_tcu_uop_sequencer.sv
// Expands one WMMA instruction into (k,m,n)-tagged micro-ops for the TCU core.
// Latency: accept at t -> first micro-op valid at t+1; one micro-op per cycle without stalls.
// Backpressure: out_ready low holds every out_* stable; in_ready only in IDLE (1-cycle bubble).
module vx_tcu_uop_sequencer
    import VX_tcu_pkg::*;
#(
    parameter int HDRW   = TCU_HDR_W,
    parameter int STEP_W = TCU_STEP_W,
    parameter int IDX_W  = TCU_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HDRW-1:0]   in_hdr,
    input  logic [STEP_W-1:0] in_m_last,
    input  logic [STEP_W-1:0] in_n_last,
    input  logic [STEP_W-1:0] in_k_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HDRW-1:0]   out_hdr,
    output logic [STEP_W-1:0] out_step_m,
    output logic [STEP_W-1:0] out_step_n,
    output logic [STEP_W-1:0] out_step_k,
    output logic              out_first,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_uop_idx,
    output logic              busy,
    output logic [31:0]       perf_stalls
);

    // The micro-op descriptor type is sized by TCU_STEP_W; STEP_W is expected to match it.
    seq_state_e        r_state;
    seq_state_e        w_state_nxt;

    logic [HDRW-1:0]   r_hdr;
    logic [STEP_W-1:0] r_m_last;
    logic [STEP_W-1:0] r_n_last;
    logic [STEP_W-1:0] r_k_last;
    logic [IDX_W-1:0]  r_uop_idx;
    logic [31:0]       r_stalls;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_fire;
    logic              w_wrap;
    logic [STEP_W-1:0] w_step_m;
    logic [STEP_W-1:0] w_step_n;
    logic [STEP_W-1:0] w_step_k;
    tcu_uop_t          w_uop;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; in_ready depends only on state, never on out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_in_ready = !reset;
                if (in_valid && !reset) begin
                    w_state_nxt = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                w_out_valid = !reset;
                w_busy      = !reset;
                if (out_ready && w_wrap) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_fire   = w_out_valid && out_ready;

    // Latch header and loop bounds when an instruction is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr    <= '0;
            r_m_last <= '0;
            r_n_last <= '0;
            r_k_last <= '0;
        end else if (w_accept) begin
            r_hdr    <= in_hdr;
            r_m_last <= in_m_last;
            r_n_last <= in_n_last;
            r_k_last <= in_k_last;
        end
    end

    // Running micro-op index, restarted for every new instruction.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_uop_idx <= '0;
        end else if (w_fire) begin
            r_uop_idx <= r_uop_idx + 1'b1;
        end
    end

    // Saturating count of cycles where a valid micro-op was refused downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stalls <= '0;
        end else if ((r_state == SEQ_ISSUE) && w_out_valid && !out_ready && (r_stalls != 32'hFFFF_FFFF)) begin
            r_stalls <= r_stalls + 32'd1;
        end
    end

    vx_tcu_step_ctr #(
        .STEP_W (STEP_W)
    ) u_step_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_inc    (w_fire),
        .i_m_last (r_m_last),
        .i_n_last (r_n_last),
        .i_k_last (r_k_last),
        .o_step_m (w_step_m),
        .o_step_n (w_step_n),
        .o_step_k (w_step_k),
        .o_wrap   (w_wrap)
    );

    // Assemble the outgoing descriptor purely from registered state.
    always_comb begin
        w_uop        = '0;
        w_uop.step_m = w_step_m;
        w_uop.step_n = w_step_n;
        w_uop.step_k = w_step_k;
        w_uop.first  = (r_uop_idx == '0);
        w_uop.last   = w_wrap;
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign busy        = w_busy;
    assign out_hdr     = r_hdr;
    assign out_step_m  = w_uop.step_m;
    assign out_step_n  = w_uop.step_n;
    assign out_step_k  = w_uop.step_k;
    assign out_first   = w_uop.first;
    assign out_last    = w_uop.last;
    assign out_uop_idx = r_uop_idx;
    assign perf_stalls = r_stalls;

endmodule

// File: tb/tb_vx_tcu_uop_sequencer.sv
// Directed bench for the micro-op sequencer: table-driven instructions plus corner sequences.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: out_ready driven per vector (always 1, or toggling 1/0).
module tb_vx_tcu_uop_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_hdr;
    logic [3:0]  in_m_last;
    logic [3:0]  in_n_last;
    logic [3:0]  in_k_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_hdr;
    logic [3:0]  out_step_m;
    logic [3:0]  out_step_n;
    logic [3:0]  out_step_k;
    logic        out_first;
    logic        out_last;
    logic [11:0] out_uop_idx;
    logic        busy;
    logic [31:0] perf_stalls;

    vx_tcu_uop_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_hdr      (in_hdr),
        .in_m_last   (in_m_last),
        .in_n_last   (in_n_last),
        .in_k_last   (in_k_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hdr     (out_hdr),
        .out_step_m  (out_step_m),
        .out_step_n  (out_step_n),
        .out_step_k  (out_step_k),
        .out_first   (out_first),
        .out_last    (out_last),
        .out_uop_idx (out_uop_idx),
        .busy        (busy),
        .perf_stalls (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hdr;
        logic [3:0]  m_last;
        logic [3:0]  n_last;
        logic [3:0]  k_last;
        bit          toggle;
        int          first_uop;
        int          n_uops;
        int          stalls;
    } instr_vec_t;

    typedef struct {
        logic [3:0]  m;
        logic [3:0]  n;
        logic [3:0]  k;
        logic        first;
        logic        last;
        logic [11:0] idx;
    } uop_vec_t;

    instr_vec_t iv[4];
    uop_vec_t   uv[13];

    int n_vec = 0;
    int n_err = 0;
    int exp_stalls = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k,
                                       input logic f, input logic l, input logic [11:0] idx);
        return 64'({m, n, k, f, l, idx});
    endfunction

    function automatic logic [63:0] got_uop();
        return pk(out_step_m, out_step_n, out_step_k, out_first, out_last, out_uop_idx);
    endfunction

    // Offer one table instruction, drain all its micro-ops and check every cycle.
    task automatic run_instr(input int v);
        instr_vec_t d;
        uop_vec_t   e;
        int         j;
        int         c;
        logic       rdy;
        d = iv[v];
        j = 0;
        c = 0;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_hdr    = d.hdr;
        in_m_last = d.m_last;
        in_n_last = d.n_last;
        in_k_last = d.k_last;
        @(negedge clk);
        in_valid  = 1'b0;
        in_hdr    = '0;
        in_m_last = 4'hF;
        in_n_last = 4'hF;
        in_k_last = 4'hF;
        while (j < d.n_uops && c < 200) begin
            e = uv[d.first_uop + j];
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            chk("out_hdr", out_hdr, d.hdr);
            chk("uop_fields", got_uop(), pk(e.m, e.n, e.k, e.first, e.last, e.idx));
            rdy = d.toggle ? ((c % 2) == 0) : 1'b1;
            out_ready = rdy;
            if (!rdy) exp_stalls++;
            @(negedge clk);
            if (rdy) j++;
            c++;
        end
        out_ready = 1'b1;
        chk("uop_count", 64'(j), 64'(d.n_uops));
        chk("done_out_valid", 64'(out_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_in_ready", 64'(in_ready), 64'd1);
        chk("perf_stalls", 64'(perf_stalls), 64'(exp_stalls));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  seen;

        iv[0] = '{64'hA5A5_0001_DEAD_BEEF, 4'd1, 4'd1, 4'd0, 1'b0, 0, 4, 0};
        iv[1] = '{64'h0000_0000_0000_0002, 4'd0, 4'd0, 4'd0, 1'b0, 4, 1, 0};
        iv[2] = '{64'hFFFF_0000_1234_5678, 4'd0, 4'd1, 4'd2, 1'b1, 5, 6, 5};
        iv[3] = '{64'hC0DE_C0DE_0000_0003, 4'd0, 4'd0, 4'd1, 1'b0, 11, 2, 0};

        uv[0]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 12'd0};
        uv[1]  = '{4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 12'd1};
        uv[2]  = '{4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 12'd2};
        uv[3]  = '{4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 12'd3};
        uv[4]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 12'd0};
        uv[5]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 12'd0};
        uv[6]  = '{4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 12'd1};
        uv[7]  = '{4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 12'd2};
        uv[8]  = '{4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 12'd3};
        uv[9]  = '{4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 12'd4};
        uv[10] = '{4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 12'd5};
        uv[11] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 12'd0};
        uv[12] = '{4'd0, 4'd0, 4'd1, 1'b0, 1'b1, 12'd1};

        // Reset state.
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_hdr    = '0;
        in_m_last = '0;
        in_n_last = '0;
        in_k_last = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_perf", 64'(perf_stalls), 64'd0);
        chk("rst_hdr", out_hdr, 64'd0);
        chk("rst_idx", 64'(out_uop_idx), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // 2x2 grid, single-uop instruction, k-major with toggling ready.
        for (int v = 0; v < 3; v++) run_instr(v);

        // Back-to-back: second request held while the first drains.
        chk("b2b_in_ready0", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_hdr    = 64'hAAAA_AAAA_0000_0001;
        in_m_last = 4'd0;
        in_n_last = 4'd1;
        in_k_last = 4'd0;
        @(negedge clk);
        chk("b2b_a0_valid", 64'(out_valid), 64'd1);
        chk("b2b_a0_hdr", out_hdr, 64'hAAAA_AAAA_0000_0001);
        chk("b2b_a0_uop", got_uop(), pk(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 12'd0));
        chk("b2b_a0_in_ready", 64'(in_ready), 64'd0);
        in_hdr    = 64'hBBBB_BBBB_0000_0002;
        in_n_last = 4'd0;
        @(negedge clk);
        chk("b2b_a1_uop", got_uop(), pk(4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 12'd1));
        chk("b2b_a1_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("b2b_bubble_valid", 64'(out_valid), 64'd0);
        chk("b2b_bubble_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_b_valid", 64'(out_valid), 64'd1);
        chk("b2b_b_hdr", out_hdr, 64'hBBBB_BBBB_0000_0002);
        chk("b2b_b_uop", got_uop(), pk(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 12'd0));
        @(negedge clk);
        chk("b2b_end_valid", 64'(out_valid), 64'd0);
        chk("b2b_end_in_ready", 64'(in_ready), 64'd1);

        // Maximum bounds: 4096 micro-ops without early wrap.
        in_valid  = 1'b1;
        in_hdr    = 64'h5555_5555_5555_5555;
        in_m_last = 4'hF;
        in_n_last = 4'hF;
        in_k_last = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (out_valid) begin
                if (cnt == 0)   chk("max_first", got_uop(), pk(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 12'd0));
                if (cnt == 16)  chk("max_m_carry", got_uop(), pk(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 12'd16));
                if (cnt == 256) chk("max_k_carry", got_uop(), pk(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 12'd256));
                if (out_last) begin
                    seen = 1'b1;
                    chk("max_last", got_uop(), pk(4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 12'd4095));
                end
                cnt++;
            end
            @(negedge clk);
        end
        chk("max_count", 64'(cnt), 64'd4096);
        chk("max_done_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of an instruction.
        in_valid  = 1'b1;
        in_hdr    = 64'h6666_0000_0000_0006;
        in_m_last = 4'd1;
        in_n_last = 4'd1;
        in_k_last = 4'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_uop2", got_uop(), pk(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 12'd2));
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd0);
        chk("rstmid_hdr", out_hdr, 64'd0);
        chk("rstmid_perf", 64'(perf_stalls), 64'd0);
        exp_stalls = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_no_uop", 64'(out_valid), 64'd0);
        run_instr(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
